// File: rtl/msg_pkg.sv
// msg_pkg: shared states, ASCII codes and a character-class helper for message_writer.
`default_nettype none

package msg_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    FULL  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_BS        = 8'h08;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_PRINT_MIN) && (c <= ASCII_PRINT_MAX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/msg_ram.sv
// msg_ram: DEPTH x 8 register file, one synchronous write port, one combinational read port.
`default_nettype none

module msg_ram #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] PAD_CHAR = 8'h20,
  localparam int        AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PAD_CHAR;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/message_writer.sv
// message_writer: edits a DEPTH-character message buffer from a valid/ready ASCII stream
// (append, backspace, CR pad, clear) and exposes a combinational addr->char_out read port.
`default_nettype none

module message_writer
  import msg_pkg::*;
#(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] PAD_CHAR = 8'h20,
  localparam int        AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    char_in,
  input  logic          char_valid,
  output logic          char_ready,
  input  logic          clear,
  input  logic [AW-1:0] addr,
  output logic [7:0]    char_out,
  output logic [AW:0]   msg_len,
  output logic          full,
  output logic          busy,
  output logic          msg_done
);

  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW:0]   wptr, wptr_nxt;
  logic [AW-1:0] sweep, sweep_nxt;
  logic          done_q, done_nxt;
  logic          accept;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  assign char_ready = (state == FILL) && !clear;
  assign accept     = char_valid && char_ready;

  always_comb begin
    state_nxt = state;
    wptr_nxt  = wptr;
    sweep_nxt = sweep;
    we        = 1'b0;
    waddr     = wptr[AW-1:0];
    wdata     = PAD_CHAR;

    // clear pre-empts every state, so nothing else may write in that cycle
    if (clear) begin
      state_nxt = CLEAR;
      sweep_nxt = '0;
      wptr_nxt  = '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (is_printable(char_in)) begin
              we       = 1'b1;
              wdata    = char_in;
              wptr_nxt = wptr + 1'b1;
              if (wptr_nxt == LEN_MAX) state_nxt = FULL;
            end else if (char_in == ASCII_BS) begin
              if (wptr != '0) begin
                wptr_nxt = wptr - 1'b1;
                we       = 1'b1;
                waddr    = wptr_nxt[AW-1:0];
              end
            end else if (char_in == ASCII_CR) begin
              state_nxt = PAD;
            end
          end
        end
        PAD: begin
          we       = 1'b1;
          wptr_nxt = wptr + 1'b1;
          if (wptr[AW-1:0] == LAST) state_nxt = FULL;
        end
        FULL: begin
        end
        CLEAR: begin
          we        = 1'b1;
          waddr     = sweep;
          sweep_nxt = sweep + 1'b1;
          if (sweep == LAST) begin
            state_nxt = FILL;
            wptr_nxt  = '0;
          end
        end
        default: state_nxt = FILL;
      endcase
    end

    done_nxt = (state_nxt == FULL) && (state != FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= FILL;
      wptr   <= '0;
      sweep  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wptr   <= wptr_nxt;
      sweep  <= sweep_nxt;
      done_q <= done_nxt;
    end
  end

  msg_ram #(
    .DEPTH    (DEPTH),
    .PAD_CHAR (PAD_CHAR)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (char_out)
  );

  assign msg_len  = wptr;
  assign full     = (wptr == LEN_MAX);
  assign busy     = (state == PAD) || (state == CLEAR);
  assign msg_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_message_writer.sv
// tb_message_writer: table vectors, directed corner sequences and random traffic
// checked against a length/flag based reference model of the message buffer.
`timescale 1ns/100ps
`default_nettype none

module tb_message_writer;

  localparam int         DEPTH = 16;
  localparam int         AW    = 4;
  localparam logic [7:0] PADC  = 8'h20;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    char_in;
  logic          char_valid;
  logic          char_ready;
  logic          clear;
  logic [AW-1:0] addr;
  logic [7:0]    char_out;
  logic [AW:0]   msg_len;
  logic          full;
  logic          busy;
  logic          msg_done;

  always #5 clk = ~clk;

  message_writer #(.DEPTH(DEPTH), .PAD_CHAR(PADC)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear      (clear),
    .addr       (addr),
    .char_out   (char_out),
    .msg_len    (msg_len),
    .full       (full),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  int checks = 0;
  int errors = 0;
  bit last_rdy;

  // Reference model: message contents, length, and whether a pad or clear sweep is running
  logic [7:0] m_buf [DEPTH];
  int         m_len;
  bit         m_clearing;
  int         m_cidx;
  bit         m_padding;
  bit         m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input bit clr);
    return !m_clearing && !m_padding && (m_len < DEPTH) && !clr;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = PADC;
    m_len = 0; m_clearing = 0; m_cidx = 0; m_padding = 0; m_done = 0;
  endtask

  task automatic model_step(input bit clr, input bit v, input logic [7:0] ch);
    m_done = 0;
    if (clr) begin
      m_clearing = 1; m_cidx = 0; m_padding = 0; m_len = 0;
    end else if (m_clearing) begin
      m_buf[m_cidx] = PADC;
      m_cidx++;
      if (m_cidx == DEPTH) m_clearing = 0;
    end else if (m_padding) begin
      m_buf[m_len] = PADC;
      m_len++;
      if (m_len == DEPTH) begin m_padding = 0; m_done = 1; end
    end else if (v && m_len < DEPTH) begin
      if (ch >= 8'h20 && ch <= 8'h7E) begin
        m_buf[m_len] = ch;
        m_len++;
        m_done = (m_len == DEPTH);
      end else if (ch == 8'h08) begin
        if (m_len > 0) begin m_len--; m_buf[m_len] = PADC; end
      end else if (ch == 8'h0D) begin
        m_padding = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("msg_len",  32'(msg_len),  32'(m_len));
    chk("full",     32'(full),     32'(m_len == DEPTH));
    chk("busy",     32'(busy),     32'(m_clearing || m_padding));
    chk("msg_done", 32'(msg_done), 32'(m_done));
  endtask

  task automatic check_buf();
    for (int i = 0; i < DEPTH; i++) begin
      addr = AW'(i);
      #0.1;
      chk("buf", 32'(char_out), 32'(m_buf[i]));
    end
  endtask

  // Called shortly after a rising edge; drives one cycle of inputs and checks both sides of the edge
  task automatic tick(input bit clr, input bit v, input logic [7:0] ch);
    logic [AW-1:0] a;
    bit exp_rdy;
    clear = clr; char_valid = v; char_in = ch;
    a = AW'($urandom_range(DEPTH - 1, 0));
    addr = a;
    exp_rdy = m_ready(clr);
    @(negedge clk);
    last_rdy = char_ready;
    chk("char_ready", 32'(char_ready), 32'(exp_rdy));
    @(posedge clk);
    model_step(clr, v, ch);
    #1;
    check_outputs();
    chk("char_out", 32'(char_out), 32'(m_buf[a]));
  endtask

  task automatic do_reset();
    reset = 1'b0; clear = 1'b0; char_valid = 1'b0; char_in = 8'h00; addr = '0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    chk("reset_ready", 32'(char_ready), 32'd1);
    reset = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    logic [7:0] ch;
    int         len;
    bit         rdy;
    string      expbuf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int dones;
    logic [7:0] c;

    vecs.push_back('{rst:1, ch:8'h48, len:1, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h45, len:2, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h4C, len:3, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h4C, len:4, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h4F, len:5, rdy:1, expbuf:"HELLO"});
    vecs.push_back('{rst:1, ch:8'h48, len:1, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h45, len:2, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h4C, len:3, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h50, len:4, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h08, len:3, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h08, len:2, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h4C, len:3, rdy:1, expbuf:""});
    vecs.push_back('{rst:0, ch:8'h4F, len:4, rdy:1, expbuf:"HELO"});
    vecs.push_back('{rst:0, ch:8'h07, len:4, rdy:1, expbuf:"HELO"});

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].rst) do_reset();
      tick(1'b0, 1'b1, vecs[k].ch);
      chk("tbl_len", 32'(msg_len), 32'(vecs[k].len));
      chk("tbl_ready", 32'(last_rdy), 32'(vecs[k].rdy));
      if (vecs[k].expbuf.len() > 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          addr = AW'(i);
          #0.1;
          if (i < vecs[k].expbuf.len()) chk("tbl_buf", 32'(char_out), 32'(vecs[k].expbuf[i]));
          else                          chk("tbl_buf", 32'(char_out), 32'(PADC));
        end
      end
    end

    // "HI" + CR: pad the remaining 14 positions, then FULL with one msg_done pulse
    do_reset();
    tick(0, 1, 8'h48);
    tick(0, 1, 8'h49);
    tick(0, 1, 8'h0D);
    cnt = busy ? 1 : 0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (full) break;
      tick(0, 0, 8'h00);
      if (busy) cnt++;
      if (msg_done) dones++;
    end
    chk("pad_reached_full", 32'(full), 32'd1);
    chk("pad_busy_cycles", 32'(cnt), 32'd14);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 8'h58);
      if (msg_done) dones++;
      chk("full_ready", 32'(last_rdy), 32'd0);
    end
    chk("pad_done_pulses", 32'(dones), 32'd1);
    chk("pad_len", 32'(msg_len), 32'd16);
    check_buf();
    addr = 4'd15; #0.1; chk("pad_addr15", 32'(char_out), 32'h20);
    addr = 4'd1;  #0.1; chk("pad_addr1", 32'(char_out), 32'h49);

    // 16 printable chars fill the buffer; a 17th is held off
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(0, 1, 8'($urandom_range(8'h7E, 8'h20)));
    chk("fill16_full", 32'(full), 32'd1);
    chk("fill16_done", 32'(msg_done), 32'd1);
    tick(0, 1, 8'h21);
    chk("fill17_ready", 32'(last_rdy), 32'd0);
    chk("fill17_done_once", 32'(msg_done), 32'd0);
    check_buf();

    // clear from FULL with a char offered alongside; sweep lasts DEPTH cycles
    tick(1, 1, 8'h5A);
    chk("clr_ready", 32'(last_rdy), 32'd0);
    chk("clr_len", 32'(msg_len), 32'd0);
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 8'h00);
      if (busy) cnt++;
      else break;
    end
    chk("clr_busy_cycles", 32'(cnt), 32'd16);
    check_buf();
    tick(0, 1, 8'h41);
    chk("after_clr_ready", 32'(last_rdy), 32'd1);
    chk("after_clr_len", 32'(msg_len), 32'd1);

    // clear re-pulsed mid-sweep restarts the full sweep
    tick(1, 0, 8'h00);
    for (int i = 0; i < 5; i++) tick(0, 0, 8'h00);
    tick(1, 0, 8'h00);
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 8'h00);
      if (busy) cnt++;
      else break;
    end
    chk("reclr_busy_cycles", 32'(cnt), 32'd16);
    check_buf();

    // reset in the middle of a CR pad takes effect without a clock edge
    do_reset();
    tick(0, 1, 8'h41);
    tick(0, 1, 8'h42);
    tick(0, 1, 8'h0D);
    for (int i = 0; i < 3; i++) tick(0, 0, 8'h00);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midpad_reset_ready", 32'(char_ready), 32'd1);
    check_buf();
    reset = 1'b1;
    tick(0, 1, 8'h08);
    chk("bs_at_zero_len", 32'(msg_len), 32'd0);
    tick(0, 1, 8'h07);
    chk("bel_ignored_len", 32'(msg_len), 32'd0);
    chk("bel_ignored_busy", 32'(busy), 32'd0);
    check_buf();

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(19, 0);
      if (r < 14)       c = 8'($urandom_range(8'h7E, 8'h20));
      else if (r < 16)  c = 8'h08;
      else if (r == 16) c = 8'h0D;
      else              c = 8'($urandom_range(255, 0));
      tick($urandom_range(49, 0) == 0, $urandom_range(9, 0) < 7, c);
      if ((n % 100) == 99) check_buf();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/message_writer.md
# message_writer

Write-side counterpart of the display's 16-character message ROM. It accepts an ASCII character stream over a valid/ready handshake, edits a 16×8 register-file message buffer (printable append, backspace, carriage-return pad), and exposes the same addr→char_out combinational read port as the ROM. The scroller/display path can therefore read a runtime-loaded message in place of the fixed one.

## Interface
- DEPTH, 16: message length in characters; power of two; AW = $clog2(DEPTH).
- PAD_CHAR, 8'h20: fill character for reset, clear, backspace and CR padding.

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- char_in  in  8  ASCII character offered
- char_valid  in  1  char_in is valid
- char_ready  out  1  block accepts char_in this cycle; = (state==FILL) && !clear
- clear  in  1  single-cycle request to blank buffer and restart
- addr  in  AW  read address
- char_out  out  8  buffer[addr], combinational
- msg_len  out  AW+1  characters written (0..DEPTH), including pad
- full  out  1  msg_len == DEPTH
- busy  out  1  state is PAD or CLEAR
- msg_done  out  1  one-cycle pulse on entry to FULL

## Operation
- States: FILL, PAD, FULL, CLEAR. Internal pointer wptr (AW+1 bits) drives msg_len.
- Accept = char_valid && char_ready. Non-accepted input has no effect.
- FILL, accepted char:
  - 0x20..0x7E: buffer[wptr] <= char_in, wptr+1. If the new wptr == DEPTH, go to FULL.
  - 0x08 (BS): if wptr > 0, wptr−1 and buffer[wptr−1] <= PAD_CHAR. At wptr == 0, consumed with no effect.
  - 0x0D (CR): go to PAD. If wptr is already DEPTH this is unreachable, because FILL is left at DEPTH.
  - Any other code: consumed and discarded.
- PAD: each cycle buffer[wptr] <= PAD_CHAR, wptr+1. After the write at DEPTH−1, go to FULL.
- FULL: hold. Buffer stays readable; char_ready = 0.
- CLEAR: sweep index s = 0..DEPTH−1, one write of PAD_CHAR per cycle. After s = DEPTH−1: wptr = 0, go to FILL.
- clear has priority in every state:
  - Next state is CLEAR, s = 0, msg_len = 0 from the next cycle.
  - A char presented in the same cycle is not accepted.
  - clear during CLEAR restarts the sweep at s = 0.
- msg_done is registered; it is high for exactly the first cycle in FULL.

## Timing
- Reset values:
  - All buffer entries PAD_CHAR.
  - wptr/msg_len = 0, state FILL.
  - full, busy, msg_done = 0.
  - char_ready = 1 (if clear low).
- Reset mid-PAD/CLEAR aborts immediately to these values.
- A write accepted in cycle n is visible on char_out (for a matching addr) in cycle n+1. No same-cycle bypass.
- Throughput in FILL: one character per cycle.
- CR accepted at msg_len = k: PAD occupies DEPTH−k cycles, then FULL with msg_done. For k = 0 that is 16 cycles.
- The 16th printable char accepted in cycle n gives full = 1 and msg_done = 1 in cycle n+1.
- clear in cycle n: CLEAR in cycles n+1..n+DEPTH, FILL with char_ready = 1 in cycle n+DEPTH+1.
- char_out depends only on addr and buffer; the read port is always live, including during PAD/CLEAR.

## Structure
- Package msg_pkg: state enum (FILL, PAD, FULL, CLEAR); ASCII_BS = 8'h08, ASCII_CR = 8'h0D, ASCII_PRINT_MIN = 8'h20, ASCII_PRINT_MAX = 8'h7E.
- Sub-module msg_ram:
  - DEPTH×8 register file, one synchronous write port (we, waddr, wdata).
  - One combinational read port.
  - Async active-low reset of all entries to PAD_CHAR.
- The top holds the FSM, pointer and sweep counter, and the write-port mux.

## Test plan
- Reset, then stream "HELLO" back-to-back → msg_len = 5, addr 0..4 read 48 45 4C 4C 4F, addr 5..15 read 20, char_ready stays 1.
- "HELP" then 0x08, 0x08, "LO" → buffer "HELO", msg_len = 4, addr 4 reads 20.
- "HI" then 0x0D → busy for 14 cycles, then full = 1, msg_done a single-cycle pulse, msg_len = 16, char_ready = 0, addr 2..15 read 20.
- 16 printable chars → full and msg_done in the cycle after the 16th. A 17th char is held with char_ready = 0 and not written.
- In FULL, pulse clear with char_valid high → char not taken, busy 16 cycles, all entries 20, msg_len = 0, then FILL accepts. Check clear re-pulsed mid-sweep restarts it.
- Assert reset in the middle of a CR pad → all outputs at reset values immediately; after release, 0x08 at msg_len = 0 and 0x07 are consumed with no state change.
